// File: rtl/mesh_wormhole_packetizer.sv
// Mesh NI injection: descriptor + payload words -> HEADER, BODY..., TAIL wormhole flits.
// One-cycle registered output; msg/pld ready drop combinationally while a flit is stalled by flit_rdy_i.
module mesh_wormhole_packetizer #(
  parameter int FLIT_DATA_W = 8,
  parameter int FLIT_ID_W   = 2,
  parameter int HOP_CNT_W   = 4,
  parameter int ROW_ADDR_W  = 2,
  parameter int COL_ADDR_W  = 2,
  parameter int LEN_W       = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             msg_vld_i,
  output logic                             msg_rdy_o,
  input  logic [ROW_ADDR_W-1:0]            msg_row_i,
  input  logic [COL_ADDR_W-1:0]            msg_col_i,
  input  logic [LEN_W-1:0]                 msg_len_i,
  input  logic [FLIT_DATA_W-1:0]           pld_data_i,
  input  logic                             pld_vld_i,
  output logic                             pld_rdy_o,
  output logic [FLIT_ID_W+FLIT_DATA_W-1:0] flit_o,
  output logic                             flit_vld_o,
  input  logic                             flit_rdy_i,
  output logic [15:0]                      pkt_sent_cnt_o
);

  if (FLIT_DATA_W != HOP_CNT_W + ROW_ADDR_W + COL_ADDR_W) begin : g_width_check
    $fatal(1, "FLIT_DATA_W must equal HOP_CNT_W+ROW_ADDR_W+COL_ADDR_W");
  end

  typedef struct packed {
    logic [FLIT_ID_W-1:0]  id;
    logic [ROW_ADDR_W-1:0] row;
    logic [COL_ADDR_W-1:0] col;
    logic [HOP_CNT_W-1:0]  hop;
  } flit_t;

  typedef enum logic {S_IDLE, S_PAYLOAD} state_e;

  localparam logic [FLIT_ID_W-1:0] ID_HEAD = FLIT_ID_W'(1);
  localparam logic [FLIT_ID_W-1:0] ID_BODY = FLIT_ID_W'(2);
  localparam logic [FLIT_ID_W-1:0] ID_TAIL = FLIT_ID_W'(3);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  flit_t            flit_q, flit_d;
  logic             flit_vld_q, flit_vld_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             load_en;
  logic             last_pld;

  // The output register can take a new flit when empty or when its current flit leaves this cycle.
  assign load_en  = ~flit_vld_q | flit_rdy_i;
  assign last_pld = (rem_q == LEN_W'(1));

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    flit_d     = flit_q;
    flit_vld_d = flit_vld_q & ~flit_rdy_i;
    msg_rdy_o  = 1'b0;
    pld_rdy_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        msg_rdy_o = load_en;
        if (msg_vld_i && load_en) begin
          flit_d.id  = ID_HEAD;
          flit_d.row = msg_row_i;
          flit_d.col = msg_col_i;
          flit_d.hop = '0;
          flit_vld_d = 1'b1;
          // A zero length still yields one payload flit so the packet always closes with a TAIL.
          rem_d      = (msg_len_i == '0) ? LEN_W'(1) : msg_len_i;
          state_d    = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        pld_rdy_o = load_en;
        if (pld_vld_i && load_en) begin
          flit_d.id                          = last_pld ? ID_TAIL : ID_BODY;
          {flit_d.row, flit_d.col, flit_d.hop} = pld_data_i;
          flit_vld_d                         = 1'b1;
          rem_d                              = rem_q - LEN_W'(1);
          if (last_pld) state_d = S_IDLE;
        end
      end
    endcase
    cnt_d = cnt_q + 16'(flit_vld_q & flit_rdy_i & (flit_q.id == ID_TAIL));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      flit_q     <= '0;
      flit_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      flit_q     <= flit_d;
      flit_vld_q <= flit_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign flit_o         = flit_q;
  assign flit_vld_o     = flit_vld_q;
  assign pkt_sent_cnt_o = cnt_q;

endmodule

// File: tb/tb_mesh_wormhole_packetizer.sv
// Randomized and directed stimulus for the wormhole packetizer, checked against a flit-list model.
module tb_mesh_wormhole_packetizer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        msg_vld_i = 1'b0;
  logic        msg_rdy_o;
  logic [1:0]  msg_row_i = '0;
  logic [1:0]  msg_col_i = '0;
  logic [3:0]  msg_len_i = '0;
  logic [7:0]  pld_data_i = '0;
  logic        pld_vld_i = 1'b0;
  logic        pld_rdy_o;
  logic [9:0]  flit_o;
  logic        flit_vld_o;
  logic        flit_rdy_i = 1'b1;
  logic [15:0] pkt_sent_cnt_o;

  mesh_wormhole_packetizer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .msg_vld_i(msg_vld_i), .msg_rdy_o(msg_rdy_o),
    .msg_row_i(msg_row_i), .msg_col_i(msg_col_i), .msg_len_i(msg_len_i),
    .pld_data_i(pld_data_i), .pld_vld_i(pld_vld_i), .pld_rdy_o(pld_rdy_o),
    .flit_o(flit_o), .flit_vld_o(flit_vld_o), .flit_rdy_i(flit_rdy_i),
    .pkt_sent_cnt_o(pkt_sent_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] row;
    logic [1:0] col;
    logic [3:0] len;
  } desc_t;

  desc_t      desc_q[$];
  logic [7:0] pld_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  int         obs_cyc[$];

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         viol = 0;
  int         exp_cnt = 0;
  bit         stall_pend = 0;
  logic [9:0] stall_flit = '0;

  // Model: a packet is its header flit followed by max(len,1) payload flits, the last one a TAIL.
  task automatic add_packet(input logic [1:0] row, input logic [1:0] col, input logic [3:0] len,
                            input logic [7:0] base, input bit rnd);
    desc_t      d;
    int         n;
    logic [7:0] w;
    n = (len == 0) ? 1 : int'(len);
    d.row = row; d.col = col; d.len = len;
    desc_q.push_back(d);
    exp_q.push_back({2'b01, row, col, 4'h0});
    for (int i = 0; i < n; i++) begin
      w = rnd ? 8'($urandom) : base + 8'(i);
      pld_q.push_back(w);
      exp_q.push_back({(i == n - 1) ? 2'b11 : 2'b10, w});
    end
    exp_cnt++;
  endtask

  task automatic clear_model();
    desc_q.delete(); pld_q.delete(); exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    stall_pend = 0;
  endtask

  // One clock: drive at negedge, sample 1ns later; handshakes recorded here complete at the next posedge.
  task automatic cycle(input bit rdy, input int mp, input int pp);
    @(negedge clk_i);
    flit_rdy_i = rdy;
    if (desc_q.size() > 0 && int'($urandom_range(99)) < mp) begin
      msg_vld_i = 1'b1;
      msg_row_i = desc_q[0].row; msg_col_i = desc_q[0].col; msg_len_i = desc_q[0].len;
    end else begin
      msg_vld_i = 1'b0;
      msg_row_i = 2'($urandom); msg_col_i = 2'($urandom); msg_len_i = 4'($urandom);
    end
    if (pld_q.size() > 0 && int'($urandom_range(99)) < pp) begin
      pld_vld_i = 1'b1; pld_data_i = pld_q[0];
    end else begin
      pld_vld_i = 1'b0; pld_data_i = 8'($urandom);
    end
    #1;
    cyc++;
    if (stall_pend && (!flit_vld_o || flit_o !== stall_flit)) viol++;
    if (flit_vld_o && !flit_rdy_i && (msg_rdy_o || pld_rdy_o)) viol++;
    stall_pend = flit_vld_o && !flit_rdy_i;
    stall_flit = flit_o;
    if (flit_vld_o && flit_rdy_i) begin
      obs_q.push_back(flit_o);
      obs_cyc.push_back(cyc);
    end
    if (msg_vld_i && msg_rdy_o) void'(desc_q.pop_front());
    if (pld_vld_i && pld_rdy_o) void'(pld_q.pop_front());
  endtask

  task automatic drain(input int rp, input int mp, input int pp);
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 3000) begin
      cycle(int'($urandom_range(99)) < rp, mp, pp);
      n++;
    end
    cycle(1'b1, 0, 0);
  endtask

  task automatic apply_reset();
    rst_i = 1'b1; msg_vld_i = 1'b0; pld_vld_i = 1'b0; flit_rdy_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    clear_model();
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (flit_vld_o !== 1'b0) begin failures++; $display("FAIL rst_vld: got %b want 0", flit_vld_o); end
    checks++; if (flit_o !== 10'h0) begin failures++; $display("FAIL rst_flit: got %h want 000", flit_o); end
    checks++; if (pkt_sent_cnt_o !== 16'h0) begin failures++; $display("FAIL rst_cnt: got %h want 0000", pkt_sent_cnt_o); end
    checks++; if (msg_rdy_o !== 1'b1) begin failures++; $display("FAIL rst_msg_rdy: got %b want 1", msg_rdy_o); end
    checks++; if (pld_rdy_o !== 1'b0) begin failures++; $display("FAIL rst_pld_rdy: got %b want 0", pld_rdy_o); end
  endtask

  task automatic test_single();
    logic [9:0] want[4];
    want[0] = 10'h190; want[1] = 10'h2A1; want[2] = 10'h2A2; want[3] = 10'h3A3;
    add_packet(2'd2, 2'd1, 4'd3, 8'hA1, 1'b0);
    drain(100, 100, 100);
    checks++; if (obs_q.size() != 4) begin failures++; $display("FAIL single_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== want[i]) begin failures++; $display("FAIL single_flit%0d: got %h want %h", i, obs_q[i], want[i]); end
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      checks++; if (obs_cyc[i] != obs_cyc[i-1] + 1) begin failures++; $display("FAIL single_gap%0d: got cycle %0d want %0d", i, obs_cyc[i], obs_cyc[i-1] + 1); end
    end
    checks++; if (pkt_sent_cnt_o !== 16'd1) begin failures++; $display("FAIL single_cnt: got %0d want 1", pkt_sent_cnt_o); end
  endtask

  task automatic test_len_zero();
    clear_model();
    add_packet(2'd3, 2'd3, 4'd0, 8'h55, 1'b0);
    drain(100, 100, 100);
    checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL len0_count: got %0d want 2", obs_q.size()); end
    if (obs_q.size() >= 2) begin
      checks++; if (obs_q[0] !== 10'h1F0) begin failures++; $display("FAIL len0_head: got %h want 1f0", obs_q[0]); end
      checks++; if (obs_q[1] !== 10'h355) begin failures++; $display("FAIL len0_tail: got %h want 355", obs_q[1]); end
    end
    checks++; if (pld_rdy_o !== 1'b0 || msg_rdy_o !== 1'b1) begin failures++; $display("FAIL len0_idle: got msg_rdy=%b pld_rdy=%b want 1/0", msg_rdy_o, pld_rdy_o); end
    checks++; if (pkt_sent_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL len0_cnt: got %0d want %0d", pkt_sent_cnt_o, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_model();
    add_packet(2'd1, 2'd2, 4'd1, 8'h11, 1'b1);
    add_packet(2'd0, 2'd3, 4'd1, 8'h22, 1'b1);
    drain(100, 100, 100);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      checks++; if (obs_cyc[i] != obs_cyc[i-1] + 1) begin failures++; $display("FAIL b2b_bubble%0d: got cycle %0d want %0d", i, obs_cyc[i], obs_cyc[i-1] + 1); end
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] held;
    int         n = 0;
    clear_model();
    viol = 0;
    add_packet(2'd1, 2'd1, 4'd6, 8'h00, 1'b1);
    while (obs_q.size() < 3 && n < 100) begin cycle(1'b1, 100, 100); n++; end
    held = flit_o;
    for (int s = 0; s < 5; s++) begin
      cycle(1'b0, 100, 100);
      checks++; if (flit_vld_o !== 1'b1 || flit_o !== exp_q[3]) begin failures++; $display("FAIL bp_hold%0d: got vld=%b flit=%h want 1/%h", s, flit_vld_o, flit_o, exp_q[3]); end
      checks++; if (pld_rdy_o !== 1'b0) begin failures++; $display("FAIL bp_pld_rdy%0d: got %b want 0", s, pld_rdy_o); end
    end
    drain(100, 100, 100);
    checks++; if (obs_q.size() != 7) begin failures++; $display("FAIL bp_count: got %0d want 7", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (viol != 0) begin failures++; $display("FAIL bp_stall_rules: got %0d violations want 0 (first held %h)", viol, held); end
  endtask

  task automatic test_starvation();
    int n = 0;
    clear_model();
    add_packet(2'd2, 2'd2, 4'd4, 8'h00, 1'b1);
    while (pld_q.size() > 2 && n < 100) begin cycle(1'b1, 100, 100); n++; end
    for (int s = 0; s < 4; s++) begin
      cycle(1'b1, 0, 0);
      if (s == 0) begin
        checks++; if (flit_vld_o !== 1'b1) begin failures++; $display("FAIL starve_pending: got vld=%b want 1", flit_vld_o); end
      end else begin
        checks++; if (flit_vld_o !== 1'b0) begin failures++; $display("FAIL starve_idle%0d: got vld=%b want 0", s, flit_vld_o); end
        checks++; if (pld_rdy_o !== 1'b1) begin failures++; $display("FAIL starve_wait%0d: got pld_rdy=%b want 1", s, pld_rdy_o); end
      end
    end
    drain(100, 100, 100);
    checks++; if (obs_q.size() != 5) begin failures++; $display("FAIL starve_count: got %0d want 5", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL starve_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    clear_model();
    add_packet(2'd3, 2'd0, 4'd4, 8'h00, 1'b1);
    while (obs_q.size() < 2 && n < 100) begin cycle(1'b1, 100, 100); n++; end
    apply_reset();
    checks++; if (flit_vld_o !== 1'b0) begin failures++; $display("FAIL mrst_vld: got %b want 0", flit_vld_o); end
    checks++; if (msg_rdy_o !== 1'b1) begin failures++; $display("FAIL mrst_msg_rdy: got %b want 1", msg_rdy_o); end
    checks++; if (pkt_sent_cnt_o !== 16'h0) begin failures++; $display("FAIL mrst_cnt: got %0d want 0", pkt_sent_cnt_o); end
    add_packet(2'd1, 2'd3, 4'd2, 8'h00, 1'b1);
    drain(100, 100, 100);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL mrst_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL mrst_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (pkt_sent_cnt_o !== 16'd1) begin failures++; $display("FAIL mrst_cnt_after: got %0d want 1", pkt_sent_cnt_o); end
  endtask

  task automatic test_random();
    clear_model();
    viol = 0;
    for (int p = 0; p < 25; p++)
      add_packet(2'($urandom), 2'($urandom), 4'($urandom), 8'h00, 1'b1);
    drain(70, 80, 80);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (pkt_sent_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL rand_cnt: got %0d want %0d", pkt_sent_cnt_o, exp_cnt); end
    checks++; if (viol != 0) begin failures++; $display("FAIL rand_stall_rules: got %0d violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_len_zero();
    test_back_to_back();
    test_backpressure();
    test_starvation();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mesh_wormhole_packetizer.md
Name: mesh_wormhole_packetizer

Overview:
Network-interface injection stage directly upstream of a mesh wormhole node's local input channel. It accepts a message descriptor (destination row/col, payload length) plus a stream of payload words from the local core. It emits a wormhole packet of one HEADER flit followed by BODY flits and a final TAIL flit, under valid/ready backpressure from the node's local input FIFO. Throughput is one flit per cycle, with no bubble between back-to-back packets.

Parameters:
- FLIT_DATA_W, 8: flit payload width; must equal HOP_CNT_W+ROW_ADDR_W+COL_ADDR_W.
- FLIT_ID_W, 2: flit type field width.
- HOP_CNT_W, 4: hop count field width in header.
- ROW_ADDR_W, 2: destination row address width.
- COL_ADDR_W, 2: destination column address width.
- LEN_W, 4: payload length field width; packets carry 1..2^LEN_W-1 payload flits.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- msg_vld_i  in  1  descriptor valid.
- msg_rdy_o  out  1  descriptor accepted when high with msg_vld_i.
- msg_row_i  in  ROW_ADDR_W  destination row.
- msg_col_i  in  COL_ADDR_W  destination column.
- msg_len_i  in  LEN_W  payload flit count.
- pld_data_i  in  FLIT_DATA_W  payload word.
- pld_vld_i  in  1  payload word valid.
- pld_rdy_o  out  1  payload word accepted when high with pld_vld_i.
- flit_o  out  FLIT_ID_W+FLIT_DATA_W  flit to node's in_chan_data_i slice.
- flit_vld_o  out  1  flit valid (node FIFO wr_en).
- flit_rdy_i  in  1  node FIFO not full (in_chan_rdy_o).
- pkt_sent_cnt_o  out  16  count of TAIL flits transferred, wraps mod 2^16.

Behaviour:
- Flit layout, MSB to LSB: [ID | row | col | hop].
- ID encoding: 2'b01 HEADER, 2'b10 BODY, 2'b11 TAIL, 2'b00 never emitted.
- Header flit: row/col = descriptor fields; hop = 0.
- BODY/TAIL flits: data field = pld_data_i, unmodified.
- Output register: flit_o/flit_vld_o registered. load_en = ~flit_vld_o | flit_rdy_i.
- flit_vld_o stays high and flit_o stays stable until flit_rdy_i=1 (transfer). flit_vld_o deasserts on transfer unless a new flit loads the same cycle.
- FSM states: IDLE, PAYLOAD. A down-counter rem (LEN_W bits) tracks payload flits left.
- IDLE:
  - msg_rdy_o = load_en; pld_rdy_o = 0.
  - On msg handshake: load HEADER; rem <= (msg_len_i==0 ? 1 : msg_len_i); go to PAYLOAD.
  - Length 0 is coerced to 1, so every packet has a TAIL.
- PAYLOAD:
  - msg_rdy_o = 0; pld_rdy_o = load_en.
  - On pld handshake: load BODY if rem>1, or TAIL if rem==1; rem <= rem-1.
  - On TAIL load, go to IDLE.
  - No pld handshake: hold state and rem; the output register may still drain.
- Latency: handshake in cycle N → flit visible on flit_o with flit_vld_o=1 in cycle N+1.
- Back-to-back: TAIL loaded in cycle N, next descriptor accepted in N+1 → HEADER on the output in N+2. No idle cycle on flit_vld_o while flit_rdy_i=1.
- Backpressure: with flit_rdy_i=0 and flit_vld_o=1, msg_rdy_o=0 and pld_rdy_o=0 (combinational from flit_rdy_i). No flit is dropped or duplicated.
- Descriptor fields are sampled only at the msg handshake. Changes on msg_*_i during PAYLOAD are ignored.
- Destination equal to the local node is still packetized normally.
- pkt_sent_cnt_o increments on a cycle where flit_vld_o & flit_rdy_i & ID==TAIL; wraps 0xFFFF→0x0000.
- Reset, applied on any cycle including mid-packet:
  - Internal state: state=IDLE, rem=0.
  - Outputs: flit_vld_o=0, flit_o=0, pkt_sent_cnt_o=0; msg_rdy_o=1, pld_rdy_o=0 (next cycle after reset deasserts).
  - A partial packet is abandoned. The downstream node is reset alongside.
- SIMULATION-only check: $fatal if FLIT_DATA_W != HOP_CNT_W+ROW_ADDR_W+COL_ADDR_W.

Test Plan:
- Single packet: row=2, col=1, len=3, payload 0xA1,0xA2,0xA3, flit_rdy_i=1 → flits 0x190 (HEADER), 0x2A1, 0x2A2, 0x3A3 on 4 consecutive cycles; pkt_sent_cnt_o=1.
- Len=0 descriptor row=3, col=3, payload 0x55 → HEADER 0x1F0 then TAIL 0x355 only; FSM returns to IDLE.
- Back-to-back: two len=1 packets with the descriptor and payload always valid → H,T,H,T on 4 consecutive cycles, flit_vld_o continuously 1.
- Backpressure: flit_rdy_i=0 for 5 cycles mid-BODY → flit_o stable, pld_rdy_o=0, no loss; after release the remaining flits arrive in order and the total flit count equals len+1.
- Payload starvation: pld_vld_i=0 for 4 cycles during PAYLOAD → flit_vld_o drops after the pending flit transfers; rem held; stream resumes correctly.
- Reset asserted after the HEADER and 1 BODY of a len=4 packet → next cycle flit_vld_o=0, msg_rdy_o=1, pkt_sent_cnt_o=0; a fresh packet after reset is emitted correctly.
